loop_arbiter: RTL and testbench

- Round-robin scheduler that shares one multi-cycle iterative engine (e.g. a Montgomery multiply loop) among NREQ requesters.
- Accepts one request at a time and tells the external operand mux which requester won.
- Issues a start pulse, then exactly ITER step strobes gated by engine back-pressure.
- Returns a completion handshake tagged with the requester id. Sits between the per-channel front ends and the shared loop stage.

---
 rtl/loop_arbiter.sv | 157 +++++++++++++++
 tb/tb_loop_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/loop_arbiter.sv
// Round-robin front end for a shared multi-cycle iterative engine: grants one
// requester, drives ITER back-pressured step strobes, then holds a tagged completion.
module loop_arbiter #(
    parameter int NREQ  = 4,
    parameter int ITER  = 256,
    parameter int ID_W  = $clog2(NREQ),
    parameter int CNT_W = $clog2(ITER)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    output logic [ID_W-1:0]  sel_id,
    output logic             eng_start,
    input  logic             eng_ready,
    output logic             eng_step,
    output logic [CNT_W-1:0] eng_iter,
    output logic             eng_last,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             any_s;
    logic [ID_W-1:0]  win_s;
    logic [ID_W-1:0]  idx_s;
    logic             last_s;

    assign last_s = (cnt_q == CNT_W'(ITER - 1));

    // Round-robin winner: scan upward from the slot after the last accepted requester.
    always_comb begin
        any_s = 1'b0;
        win_s = '0;
        idx_s = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (idx_s == ID_W'(NREQ - 1)) begin
                idx_s = '0;
            end else begin
                idx_s = idx_s + ID_W'(1);
            end
            if (!any_s && req_valid[idx_s]) begin
                any_s = 1'b1;
                win_s = idx_s;
            end else begin
                any_s = any_s;
            end
        end
    end

    // Next-state logic for the scheduler FSM, iteration counter and pointers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    grant_d = win_s;
                    ptr_d   = win_s;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Terminal compare precedes the increment, so the counter never wraps.
                if (eng_ready) begin
                    if (last_s) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decoded from the current state; grant and start are same-cycle in IDLE.
    always_comb begin
        req_ready = '0;
        eng_start = 1'b0;
        sel_id    = grant_q;
        eng_step  = 1'b0;
        eng_last  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                sel_id = win_s;
                if (any_s) begin
                    req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    eng_start = 1'b1;
                end else begin
                    req_ready = '0;
                    eng_start = 1'b0;
                end
            end
            RUN: begin
                eng_step = eng_ready;
                eng_last = last_s;
            end
            HOLD: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    assign eng_iter = cnt_q;
    assign rsp_id   = grant_q;
    assign busy     = (state_q != IDLE);

    // State registers; reset drops any in-flight operation and re-arms requester 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= ID_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_loop_arbiter.sv
// Directed bench for loop_arbiter with NREQ=4, ITER=4; expected values hand-derived.
module tb_loop_arbiter;

    localparam int NREQ  = 4;
    localparam int ITER  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [ID_W-1:0]  sel_id;
    logic             eng_start;
    logic             eng_ready;
    logic             eng_step;
    logic [CNT_W-1:0] eng_iter;
    logic             eng_last;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int nsteps;

    always #5 clk = ~clk;

    loop_arbiter #(.NREQ(NREQ), .ITER(ITER), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .sel_id(sel_id), .eng_start(eng_start), .eng_ready(eng_ready),
        .eng_step(eng_step), .eng_iter(eng_iter), .eng_last(eng_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Full operation with eng_ready and rsp_ready high: accept, ITER steps, one HOLD cycle.
    task automatic op(input logic [3:0] rv, input int id, input bit keep, input string tag);
        req_valid = rv;
        eng_ready = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk({tag, ":req_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        chk({tag, ":eng_start"}, 32'(eng_start), 32'd1);
        chk({tag, ":sel_id"},    32'(sel_id),    32'(id));
        nxt();
        if (!keep) req_valid = 4'b0000;
        for (int k = 0; k < ITER; k++) begin
            #1;
            chk({tag, ":step"},      32'(eng_step),  32'd1);
            chk({tag, ":iter"},      32'(eng_iter),  32'(k));
            chk({tag, ":last"},      32'(eng_last),  32'(k == ITER - 1));
            chk({tag, ":run_ready"}, 32'(req_ready), 32'd0);
            chk({tag, ":run_start"}, 32'(eng_start), 32'd0);
            nxt();
        end
        #1;
        chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ":rsp_id"},    32'(rsp_id),    32'(id));
        chk({tag, ":hold_step"}, 32'(eng_step),  32'd0);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic bp [7];
        int   it [7];
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        it = '{0, 1, 1, 1, 2, 3, 3};

        rst = 1'b1; req_valid = 4'b0000; eng_ready = 1'b0; rsp_ready = 1'b0;
        nxt(); nxt();
        chk("rst:busy",      32'(busy),      32'd0);
        chk("rst:req_ready", 32'(req_ready), 32'd0);
        chk("rst:eng_start", 32'(eng_start), 32'd0);
        chk("rst:eng_step",  32'(eng_step),  32'd0);
        chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst:eng_iter",  32'(eng_iter),  32'd0);
        chk("rst:eng_last",  32'(eng_last),  32'd0);
        chk("rst:rsp_id",    32'(rsp_id),    32'd0);
        rst = 1'b0;
        nxt();

        // Single request from requester 2.
        op(4'b0100, 2, 1'b0, "single");
        #1;
        chk("single:busy_after", 32'(busy), 32'd0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;

        // All requesters valid: order 0,1,2,3,0, back-to-back every ITER+2 cycles.
        for (int i = 0; i < 5; i++) op(4'b1111, i % 4, 1'b1, "rr");
        req_valid = 4'b0000;

        // Pointer at 0: only requester 3 valid, then requester 1 after grant 3.
        op(4'b1000, 3, 1'b0, "to3");

        req_valid = 4'b0010; eng_ready = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("skip:req_ready", 32'(req_ready), 32'b0010);
        chk("skip:sel_id",    32'(sel_id),    32'd1);
        nxt();
        req_valid = 4'b0000;

        // Engine back-pressure.
        nsteps = 0;
        for (int k = 0; k < 7; k++) begin
            eng_ready = bp[k];
            #1;
            chk("bp:step", 32'(eng_step), 32'(bp[k]));
            chk("bp:iter", 32'(eng_iter), 32'(it[k]));
            chk("bp:busy", 32'(busy),     32'd1);
            if (eng_step) nsteps++;
            nxt();
        end
        chk("bp:nsteps", 32'(nsteps), 32'd4);

        // Response stall with competing requests pending.
        eng_ready = 1'b1; rsp_ready = 1'b0; req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall:rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall:rsp_id",    32'(rsp_id),    32'd1);
            chk("stall:req_ready", 32'(req_ready), 32'd0);
            chk("stall:eng_start", 32'(eng_start), 32'd0);
            chk("stall:eng_step",  32'(eng_step),  32'd0);
            nxt();
        end
        rsp_ready = 1'b1;
        #1;
        chk("stall:release", 32'(rsp_valid), 32'd1);
        nxt();

        // Last grant 1, requests 0 and 1: scan 2,3,0 picks 0.
        op(4'b0011, 0, 1'b0, "wrap");

        // Reset in the middle of RUN at iteration 2.
        req_valid = 4'b0100; eng_ready = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("mid:req_ready", 32'(req_ready), 32'b0100);
        nxt();
        req_valid = 4'b0000;
        #1; chk("mid:iter0", 32'(eng_iter), 32'd0);
        nxt();
        #1; chk("mid:iter1", 32'(eng_iter), 32'd1);
        nxt();
        #1; chk("mid:iter2", 32'(eng_iter), 32'd2);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        chk("mid:busy",      32'(busy),      32'd0);
        chk("mid:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid:eng_step",  32'(eng_step),  32'd0);
        chk("mid:eng_iter",  32'(eng_iter),  32'd0);
        op(4'b0101, 0, 1'b0, "postrst");
        #1;
        chk("end:busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
